// File: rtl/fifo_rd_ctrl.sv
// ============================================================================
// Module      : fifo_rd_ctrl
// Description : Async FIFO read-side controller (read clock domain). Owns the
//               binary/Gray read pointer, empty flag and a one-deep output
//               register with a valid/ready handshake.
//               Optional occupancy output enabled by macro FIFO_RD_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_ctrl #(
    parameter int MEM_DEPTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_SIZE   = $clog2(MEM_DEPTH) + 1,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [PTR_SIZE-1:0]   RQ2_W_PTR,
    input  logic [DATA_WIDTH-1:0] R_RD_DATA,
    output logic [ADDR_WIDTH-1:0] R_ADDR,
    output logic [PTR_SIZE-1:0]   R_PTR,
    output logic                  R_EMPTY,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  O_VALID,
    input  logic                  I_READY,
    output logic [PTR_SIZE-1:0]   R_LEVEL
);

    logic [PTR_SIZE-1:0]   ptr_bin_q,  ptr_bin_d;
    logic [PTR_SIZE-1:0]   ptr_gray_q, ptr_gray_d;
    logic [DATA_WIDTH-1:0] data_q,     data_d;
    logic                  valid_q,    valid_d;
    logic                  w_pop;
    logic [PTR_SIZE-1:0]   w_ptr_bin_inc;

    // Full-width compare: the wrap bit separates empty from full.
    assign R_EMPTY       = (ptr_gray_q == RQ2_W_PTR);
    assign w_pop         = ~R_EMPTY & (~valid_q | I_READY);
    assign w_ptr_bin_inc = ptr_bin_q + PTR_SIZE'(1);

    always_comb begin
        ptr_bin_d  = ptr_bin_q;
        ptr_gray_d = ptr_gray_q;
        data_d     = data_q;
        valid_d    = valid_q;
        if (w_pop) begin
            data_d     = R_RD_DATA;
            valid_d    = 1'b1;
            ptr_bin_d  = w_ptr_bin_inc;
            ptr_gray_d = w_ptr_bin_inc ^ (w_ptr_bin_inc >> 1);
        end else if (valid_q && I_READY) begin
            valid_d    = 1'b0;
        end
    end

    // Gray pointer is registered so the write-domain synchroniser never
    // samples a combinational glitch.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_d;
            ptr_gray_q <= ptr_gray_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    assign R_ADDR  = ptr_bin_q[ADDR_WIDTH-1:0];
    assign R_PTR   = ptr_gray_q;
    assign O_DATA  = data_q;
    assign O_VALID = valid_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [PTR_SIZE-1:0] w_wbin;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i < PTR_SIZE; i++) begin
            w_wbin[i] = ^(RQ2_W_PTR >> i);
        end
    end

    assign R_LEVEL = R_RST ? '0 : (w_wbin - ptr_bin_q);
`else
    assign R_LEVEL = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ============================================================================
// Module      : tb_fifo_rd_ctrl
// Description : Self-checking bench for fifo_rd_ctrl against a count-based
//               reference model of the FIFO read side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int PS    = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PS-1:0] rq2_w_ptr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] r_addr;
    logic [PS-1:0] r_ptr;
    logic          r_empty;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [PS-1:0] r_level;

    logic [DW-1:0] mem [DEPTH];

    int checks   = 0;
    int failures = 0;

    // Reference model: counts of entries written/read and the output slot.
    logic [PS-1:0] wcnt;
    logic [PS-1:0] rcnt;
    logic          m_valid;
    logic [DW-1:0] m_data;

    fifo_rd_ctrl #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .R_CLK     (clk),
        .R_RST     (rst),
        .RQ2_W_PTR (rq2_w_ptr),
        .R_RD_DATA (rd_data),
        .R_ADDR    (r_addr),
        .R_PTR     (r_ptr),
        .R_EMPTY   (r_empty),
        .O_DATA    (o_data),
        .O_VALID   (o_valid),
        .I_READY   (i_ready),
        .R_LEVEL   (r_level)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[r_addr];

    function automatic logic [PS-1:0] gray(input logic [PS-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [PS-1:0] exp_level();
`ifdef FIFO_RD_LEVEL_EN
        return rst ? '0 : PS'(wcnt - rcnt);
`else
        return '0;
`endif
    endfunction

    // One read-clock cycle: optional write, set ready, check comb outputs,
    // advance the model, then check registered outputs after the edge.
    task automatic cycle(input bit do_push, input logic [DW-1:0] d, input logic rdy);
        bit pop;
        if (do_push && (PS'(wcnt - rcnt) < PS'(DEPTH))) begin
            mem[wcnt[AW-1:0]] = d;
            wcnt = wcnt + 1'b1;
        end
        rq2_w_ptr = gray(wcnt);
        i_ready   = rdy;
        #1;
        chk("empty", 32'(r_empty), 32'(wcnt == rcnt));
        chk("level", 32'(r_level), 32'(exp_level()));
        pop = (wcnt != rcnt) && (!m_valid || rdy);
        if (pop) begin
            m_data  = mem[rcnt[AW-1:0]];
            m_valid = 1'b1;
            rcnt    = rcnt + 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        if (m_valid) chk("o_data", 32'(o_data), 32'(m_data));
        chk("r_ptr", 32'(r_ptr), 32'(gray(rcnt)));
        chk("r_addr", 32'(r_addr), 32'(rcnt[AW-1:0]));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        wcnt = '0; rcnt = '0; m_valid = 1'b0; m_data = '0;
        rst = 1'b1; rq2_w_ptr = '0; i_ready = 1'b0;
        #1;
        chk("rst_empty", 32'(r_empty), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ptr",   32'(r_ptr),   32'd0);
        chk("rst_addr",  32'(r_addr),  32'd0);
        chk("rst_level", 32'(r_level), 32'd0);
        #12 rst = 1'b0;

        // Single entry through with consumer ready.
        cycle(1'b1, 8'hA5, 1'b1);
        chk("t2_data", 32'(o_data), 32'hA5);
        chk("t2_ptr",  32'(r_ptr),  32'b0001);
        cycle(1'b0, 8'h00, 1'b1);
        chk("t2_valid_drop", 32'(o_valid), 32'd0);
        #1 chk("t2_empty", 32'(r_empty), 32'd1);

        // Fill to 8 written, hold back-pressure, then drain.
        for (int i = 0; i < 7; i++) begin
            mem[wcnt[AW-1:0]] = DW'($urandom);
            wcnt = wcnt + 1'b1;
        end
        chk("t3_wptr", 32'(gray(wcnt)), 32'b1100);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("t3_hold_ptr", 32'(r_ptr), 32'b0011);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("t3_end_ptr", 32'(r_ptr), 32'b1100);
        chk("t3_end_valid", 32'(o_valid), 32'd0);

        // Stream 16 more entries through, exercising both wraps.
        for (int i = 0; i < 20; i++) cycle(i < 16, DW'($urandom), 1'b1);
        chk("t4_ptr", 32'(r_ptr), 32'(gray(PS'(24))));

        // Random writes and back-pressure.
        for (int i = 0; i < 300; i++)
            cycle(($urandom % 3) != 0, DW'($urandom), ($urandom % 4) != 0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("rand_drained", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ptr",   32'(r_ptr),   32'd0);
        chk("arst_addr",  32'(r_addr),  32'd0);
        chk("arst_level", 32'(r_level), 32'd0);
        wcnt = '0; rcnt = '0; m_valid = 1'b0;
        rq2_w_ptr = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("arst_empty", 32'(r_empty), 32'd1);

        // Level walk: five entries, two pops.
        for (int i = 0; i < 5; i++) begin
            mem[wcnt[AW-1:0]] = DW'($urandom);
            wcnt = wcnt + 1'b1;
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("final_empty_ptr", 32'(r_ptr), 32'(gray(PS'(5))));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
